// File: rtl/node_pkg.sv
// node_pkg: flit header layout, port directions and the XY route decode shared by node blocks.
package node_pkg;
    localparam int DefPayloadWidth = 32;
    localparam int DefLgNumprocs = 3;
    localparam int CoordWidth = 3;
    localparam int OpWidth = 4;
    localparam int TagWidth = 36;
    localparam int payloadPos = 0;
    localparam int opPos = payloadPos + DefPayloadWidth;
    localparam int tagPos = opPos + OpWidth;
    localparam int DstXPos = tagPos + TagWidth;
    localparam int DstYPos = DstXPos + CoordWidth;
    localparam int DstZPos = DstYPos + CoordWidth;
    localparam int ValidBitPos = DstZPos + CoordWidth;
    localparam int FlitWidth = ValidBitPos + 1;
    localparam int FlitChildWidth = FlitWidth + DefLgNumprocs;

    typedef enum logic [2:0] {XPOS, YPOS, XNEG, YNEG, LOCAL} port_e;
    typedef enum logic {IDLE, SEND} stage_e;

    function automatic port_e route_dir(input logic [2:0] dst_x, input logic [2:0] dst_y,
                                        input logic [2:0] cur_x, input logic [2:0] cur_y);
        return dst_x > cur_x ? XPOS : dst_x < cur_x ? XNEG :
               dst_y > cur_y ? YPOS : dst_y < cur_y ? YNEG : LOCAL;
    endfunction
endpackage

// File: rtl/large_buffer.sv
// large_buffer: show-ahead FIFO; the head is readable while not empty, and a full FIFO
// accepts a write in the same cycle as a read.
module large_buffer #(
    parameter int buffer_depth = 8,
    parameter int buffer_width = 85
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [buffer_width-1:0] wr_data,
    input  logic                    wr_en,
    input  logic                    rd_en,
    output logic [buffer_width-1:0] rd_data,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(buffer_depth);
    logic [buffer_width-1:0] mem [buffer_depth];
    logic [AW:0] wp, rp;
    logic push, pop;
    assign pop = rd_en && !empty;
    assign push = wr_en && (!full || pop);
    assign empty = wp == rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rd_data = mem[rp[AW-1:0]];
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + (AW+1)'(1);
            if (pop) rp <= rp + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/reduce_result_injector.sv
// reduce_result_injector: buffers reduce_unit results and routes them XY onto the four
// router inject ports or the local delivery port, one in-order pop per cycle.
module reduce_result_injector import node_pkg::*; #(
    parameter logic [2:0] cur_x = 3'd0,
    parameter logic [2:0] cur_y = 3'd0,
    parameter logic [2:0] cur_z = 3'd0,
    parameter int lg_numprocs = 3,
    parameter int PayloadWidth = 32,
    parameter int DEPTH = 8,
    localparam int Shift = PayloadWidth - DefPayloadWidth,
    localparam int FW = FlitWidth + Shift,
    localparam int FCW = FW + lg_numprocs
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [FCW-1:0] res_flit,
    input  logic           res_valid,
    output logic           res_ready,
    output logic [FCW-1:0] inject_xpos,
    output logic [FCW-1:0] inject_ypos,
    output logic [FCW-1:0] inject_xneg,
    output logic [FCW-1:0] inject_yneg,
    input  logic           inject_xpos_ready,
    input  logic           inject_ypos_ready,
    input  logic           inject_xneg_ready,
    input  logic           inject_yneg_ready,
    output logic [FCW-1:0] local_out,
    output logic           overflow,
    output logic [15:0]    sent_count
);
    localparam int dxp = DstXPos + Shift;
    localparam int dyp = DstYPos + Shift;
    localparam int dzp = DstZPos + Shift;
    localparam int vp = ValidBitPos + Shift;

    logic [FCW-1:0] head, flit, ldata;
    logic [FCW-1:0] data [4];
    stage_e st [4], st_nx [4];
    logic [3:0] rdy, done, load;
    logic full, empty, pop, lvld;
    logic unused_z;
    port_e dir;

    large_buffer #(.buffer_depth(DEPTH), .buffer_width(FCW)) u_fifo (
        .clk(clk),
        .rst(rst),
        .wr_data(res_flit),
        .wr_en(res_valid),
        .rd_en(pop),
        .rd_data(head),
        .full(full),
        .empty(empty)
    );

    assign rdy = {inject_yneg_ready, inject_xneg_ready, inject_ypos_ready, inject_xpos_ready};
    assign dir = route_dir(head[dxp+:3], head[dyp+:3], cur_x, cur_y);
    assign flit = head | (FCW'(1) << vp);
    assign unused_z = ^(head[dzp+:3] ^ cur_z);
    assign res_ready = !full;

    // A stage can take the head when empty or when its held flit leaves this same cycle.
    always_comb begin
        pop = !empty && (dir == LOCAL || st[dir[1:0]] == IDLE || rdy[dir[1:0]]);
        for (int i = 0; i < 4; i++) begin
            done[i] = st[i] == SEND && rdy[i];
            load[i] = pop && dir == port_e'(i);
            st_nx[i] = load[i] ? SEND : done[i] ? IDLE : st[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            st[i] <= rst ? IDLE : st_nx[i];
            if (load[i]) data[i] <= flit;
        end
        lvld <= !rst && pop && dir == LOCAL;
        ldata <= flit;
        if (rst) begin
            overflow <= 1'b0;
            sent_count <= '0;
        end else begin
            overflow <= overflow | (res_valid && full && !pop);
            sent_count <= sent_count + 16'($countones({lvld, done}));
        end
    end

    assign inject_xpos = st[0] == SEND ? data[0] : '0;
    assign inject_ypos = st[1] == SEND ? data[1] : '0;
    assign inject_xneg = st[2] == SEND ? data[2] : '0;
    assign inject_yneg = st[3] == SEND ? data[3] : '0;
    assign local_out = lvld ? ldata : '0;
endmodule

// File: tb/tb_reduce_result_injector.sv
// tb_reduce_result_injector: directed scenarios at node (2,2) followed by random traffic
// scored against per-port expected queues.
module tb_reduce_result_injector;
    import node_pkg::*;
    localparam int FCW = FlitChildWidth;
    localparam int VP = ValidBitPos;
    localparam int DEPTH = 8;
    typedef logic [FCW-1:0] flit_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    flit_t res_flit = '0;
    logic res_valid = 1'b0;
    logic res_ready, overflow;
    flit_t inject_xpos, inject_ypos, inject_xneg, inject_yneg, local_out;
    logic [3:0] rdy = 4'hF;
    logic [15:0] sent_count;
    flit_t o [4];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    reduce_result_injector #(.cur_x(3'd2), .cur_y(3'd2), .cur_z(3'd0), .lg_numprocs(3),
                             .PayloadWidth(32), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .res_flit(res_flit),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .inject_xpos(inject_xpos),
        .inject_ypos(inject_ypos),
        .inject_xneg(inject_xneg),
        .inject_yneg(inject_yneg),
        .inject_xpos_ready(rdy[0]),
        .inject_ypos_ready(rdy[1]),
        .inject_xneg_ready(rdy[2]),
        .inject_yneg_ready(rdy[3]),
        .local_out(local_out),
        .overflow(overflow),
        .sent_count(sent_count)
    );

    assign o[0] = inject_xpos;
    assign o[1] = inject_ypos;
    assign o[2] = inject_xneg;
    assign o[3] = inject_yneg;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input flit_t f);
        res_flit = f;
        res_valid = 1'b1;
        cyc();
        res_valid = 1'b0;
    endtask

    function automatic flit_t mk(input int dx, input int dy);
        flit_t f;
        f = flit_t'({$urandom, $urandom, $urandom});
        f[DstXPos+:3] = 3'(dx);
        f[DstYPos+:3] = 3'(dy);
        return f;
    endfunction

    function automatic flit_t ex(input flit_t f);
        flit_t e;
        e = f;
        e[VP] = 1'b1;
        return e;
    endfunction

    function automatic int port_of(input flit_t f);
        int dx, dy;
        dx = int'(f[DstXPos+:3]);
        dy = int'(f[DstYPos+:3]);
        if (dx > 2) return 0;
        if (dx < 2) return 2;
        if (dy > 2) return 1;
        if (dy < 2) return 3;
        return 4;
    endfunction

    function automatic flit_t any_out();
        return inject_xpos | inject_ypos | inject_xneg | inject_yneg | local_out;
    endfunction

    flit_t a, b, c, w;
    flit_t f3 [3];
    flit_t g [DEPTH+2];
    flit_t q [5][$];
    flit_t held [4];
    bit hv [4];
    int dlv;

    initial begin
        cyc();
        cyc();
        check("rst_out", any_out(), 0);
        check("rst_ready", res_ready, 1);
        check("rst_ovf", overflow, 0);
        check("rst_cnt", sent_count, 0);
        rst = 1'b0;

        a = mk(5, 1);
        push(a);
        cyc();
        check("t1_xpos", inject_xpos, ex(a));
        check("t1_cnt0", sent_count, 0);
        cyc();
        check("t1_cnt", sent_count, 1);
        check("t1_idle", inject_xpos, 0);

        b = mk(2, 0);
        c = mk(2, 2);
        res_flit = b;
        res_valid = 1'b1;
        cyc();
        res_flit = c;
        cyc();
        res_valid = 1'b0;
        check("t2_yneg", inject_yneg, ex(b));
        check("t2_nolocal", local_out, 0);
        cyc();
        check("t2_local", local_out, ex(c));
        check("t2_yneg_gone", inject_yneg, 0);
        cyc();
        check("t2_local_1cyc", local_out, 0);
        check("t2_cnt", sent_count, 3);

        rdy[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            f3[i] = mk(6, $urandom_range(0, 7));
            push(f3[i]);
        end
        for (int i = 0; i < 5; i++) begin
            check("t3_hold", inject_xpos, ex(f3[0]));
            cyc();
        end
        rdy[0] = 1'b1;
        check("t3_f0", inject_xpos, ex(f3[0]));
        cyc();
        check("t3_f1", inject_xpos, ex(f3[1]));
        cyc();
        check("t3_f2", inject_xpos, ex(f3[2]));
        cyc();
        check("t3_done", inject_xpos, 0);
        check("t3_cnt", sent_count, 6);

        rdy[0] = 1'b0;
        a = mk(7, 0);
        b = mk(3, 6);
        c = mk(2, 5);
        push(a);
        push(b);
        push(c);
        for (int i = 0; i < 4; i++) begin
            check("t4_hol_ypos", inject_ypos, 0);
            check("t4_hol_xpos", inject_xpos, ex(a));
            cyc();
        end
        rdy[0] = 1'b1;
        cyc();
        check("t4_x2", inject_xpos, ex(b));
        check("t4_y_wait", inject_ypos, 0);
        cyc();
        check("t4_y1", inject_ypos, ex(c));
        check("t4_x_idle", inject_xpos, 0);
        cyc();
        check("t4_cnt", sent_count, 9);

        rdy[0] = 1'b0;
        w = mk(4, 4);
        push(w);
        cyc();
        for (int i = 0; i < DEPTH + 2; i++) begin
            g[i] = mk(3 + (i % 5), $urandom_range(0, 7));
            check("t5_ready", res_ready, (i < DEPTH) ? 1 : 0);
            res_flit = g[i];
            res_valid = 1'b1;
            cyc();
        end
        res_valid = 1'b0;
        check("t5_full", res_ready, 0);
        check("t5_ovf", overflow, 1);
        cyc();
        cyc();
        check("t5_ovf_sticky", overflow, 1);
        check("t5_w", inject_xpos, ex(w));
        rdy[0] = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            cyc();
            check("t5_drain", inject_xpos, ex(g[i]));
        end
        cyc();
        check("t5_no_extra", inject_xpos, 0);
        check("t5_cnt", sent_count, 10 + DEPTH);
        check("t5_ovf_kept", overflow, 1);

        rdy[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            f3[i] = mk(i, $urandom_range(0, 7));
            push(f3[i]);
        end
        check("t6_xneg", inject_xneg, ex(f3[0]));
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("t6_out", any_out(), 0);
        check("t6_cnt", sent_count, 0);
        check("t6_ovf", overflow, 0);
        check("t6_ready", res_ready, 1);
        rdy[2] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("t6_post_rst", any_out(), 0);
        end

        rst = 1'b1;
        rdy = 4'hF;
        cyc();
        rst = 1'b0;
        dlv = 0;
        for (int c0 = 0; c0 < 3000; c0++) begin
            bit drain;
            drain = c0 >= 2960;
            rdy = drain ? 4'hF : (4'($urandom) | 4'($urandom));
            check("rnd_cnt", sent_count, 16'(dlv));
            if (!drain && res_ready && $urandom_range(0, 1) == 1) begin
                a = mk($urandom_range(0, 7), $urandom_range(0, 7));
                q[port_of(a)].push_back(ex(a));
                res_flit = a;
                res_valid = 1'b1;
            end else begin
                res_valid = 1'b0;
            end
            for (int p = 0; p < 4; p++) begin
                if (hv[p]) check("rnd_hold", o[p], held[p]);
                hv[p] = 1'b0;
                if (o[p][VP]) begin
                    if (rdy[p]) begin
                        dlv++;
                        if (q[p].size() == 0) check("rnd_extra", o[p], 0);
                        else check("rnd_data", o[p], q[p].pop_front());
                    end else begin
                        hv[p] = 1'b1;
                        held[p] = o[p];
                    end
                end
            end
            if (local_out[VP]) begin
                dlv++;
                if (q[4].size() == 0) check("rnd_local_extra", local_out, 0);
                else check("rnd_local", local_out, q[4].pop_front());
            end
            cyc();
        end
        res_valid = 1'b0;
        for (int p = 0; p < 5; p++) check("rnd_left", q[p].size(), 0);
        check("rnd_ovf", overflow, 0);
        check("rnd_cnt_end", sent_count, 16'(dlv));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
